fft_run_ctrl: RTL

// - Top-level sequencer for one FFT run: accepts start + point size, streams input samples into

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_beat_addr_gen.sv | 35 +++
 rtl/fft_run_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared run-state encoding and beat geometry for the FFT run controller.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ARM     = 3'd2,
    COMPUTE = 3'd3,
    UNLOAD  = 3'd4,
    ERROR   = 3'd5
  } run_state_t;

  localparam int BEAT_SAMPLES = 4;

  // Base address of the final beat for N = 8 << cfg points.
  function automatic logic [15:0] last_addr(input logic [2:0] cfg);
    return (16'd8 << cfg) - 16'(BEAT_SAMPLES);
  endfunction

endpackage

// File: rtl/fft_beat_addr_gen.sv
// Beat base-address counter: steps BEAT_SAMPLES per advance, holds at the last beat.
// Registered address, combinational last flag; advance is ignored once at the last beat.
module fft_beat_addr_gen
  import fft_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_resetn,
  input  logic          i_clear,
  input  logic          i_advance,
  input  logic [2:0]    i_cfg,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_last_addr;

  assign w_last_addr = AW'(last_addr(i_cfg));

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_advance && !o_last) begin
      r_addr <= r_addr + AW'(BEAT_SAMPLES);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == w_last_addr);

endmodule

// File: rtl/fft_run_ctrl.sv
// One-run FFT sequencer: start -> load beats -> arm -> compute (timeout) -> unload beats.
// All outputs registered (1-cycle response); load/unload stall indefinitely on host valid/ready.
module fft_run_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int          AW          = 10
) (
  input  logic          clk,
  input  logic          i_resetn,
  input  logic          i_start,
  input  logic [2:0]    i_point_cfg,
  input  logic          i_abort,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  output logic [AW-1:0] o_ld_addr,
  output logic [2:0]    o_point_cfg,
  output logic          o_dp_resetn,
  output logic          o_working,
  input  logic          i_fft_done,
  input  logic          i_bank_sel,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_rd_bank,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [15:0]   o_cycles
);

  run_state_t r_state;
  logic       r_ld_ready;
  logic       r_working;
  logic       r_rd_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       r_dp_resetn;
  logic       r_rd_bank;
  logic [2:0] r_point_cfg;
  logic [15:0] r_cycles;

  logic          w_start;
  logic          w_ld_fire;
  logic          w_rd_fire;
  logic          w_ld_last;
  logic          w_rd_last;
  logic [15:0]   w_cyc_inc;
  logic [AW-1:0] w_ld_addr;
  logic [AW-1:0] w_rd_addr;

  // Abort masks every handshake so no address moves on the abort cycle.
  assign w_start   = (r_state == IDLE) && i_start && !i_abort;
  assign w_ld_fire = (r_state == LOAD) && r_ld_ready && i_ld_valid && !i_abort;
  assign w_rd_fire = (r_state == UNLOAD) && r_rd_valid && i_rd_ready && !i_abort;
  assign w_cyc_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;

  fft_beat_addr_gen #(.AW(AW)) u_ld_addr (
    .clk       (clk),
    .i_resetn  (i_resetn),
    .i_clear   (w_start),
    .i_advance (w_ld_fire),
    .i_cfg     (r_point_cfg),
    .o_addr    (w_ld_addr),
    .o_last    (w_ld_last)
  );

  fft_beat_addr_gen #(.AW(AW)) u_rd_addr (
    .clk       (clk),
    .i_resetn  (i_resetn),
    .i_clear   (w_start),
    .i_advance (w_rd_fire),
    .i_cfg     (r_point_cfg),
    .o_addr    (w_rd_addr),
    .o_last    (w_rd_last)
  );

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= IDLE;
      r_ld_ready  <= 1'b0;
      r_working   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_dp_resetn <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_point_cfg <= 3'd0;
      r_cycles    <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_ld_ready  <= 1'b0;
        r_working   <= 1'b0;
        r_rd_valid  <= 1'b0;
        r_dp_resetn <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dp_resetn <= 1'b0;
            if (i_start) begin
              r_point_cfg <= i_point_cfg;
              r_cycles    <= 16'd0;
              r_error     <= 1'b0;
              r_ld_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= LOAD;
            end
          end
          LOAD: begin
            if (w_ld_fire && w_ld_last) begin
              r_ld_ready  <= 1'b0;
              r_dp_resetn <= 1'b1;
              r_state     <= ARM;
            end
          end
          ARM: begin
            r_working <= 1'b1;
            r_state   <= COMPUTE;
          end
          COMPUTE: begin
            r_cycles <= w_cyc_inc;
            // Done is checked first so it wins over a coincident timeout.
            if (i_fft_done) begin
              r_rd_bank  <= i_bank_sel;
              r_working  <= 1'b0;
              r_rd_valid <= 1'b1;
              r_state    <= UNLOAD;
            end else if (w_cyc_inc >= 16'(TIMEOUT_CYC)) begin
              r_error     <= 1'b1;
              r_working   <= 1'b0;
              r_dp_resetn <= 1'b0;
              r_state     <= ERROR;
            end
          end
          UNLOAD: begin
            if (w_rd_fire && w_rd_last) begin
              r_rd_valid  <= 1'b0;
              r_done      <= 1'b1;
              r_dp_resetn <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end
          end
          ERROR: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_working   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_dp_resetn <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ld_ready  = r_ld_ready;
  assign o_ld_addr   = w_ld_addr;
  assign o_point_cfg = r_point_cfg;
  assign o_dp_resetn = r_dp_resetn;
  assign o_working   = r_working;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_addr   = w_rd_addr;
  assign o_rd_bank   = r_rd_bank;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_cycles    = r_cycles;

endmodule
